// File: rtl/barrel_shift_cmd_queue.sv
// barrel_shift_cmd_queue
// Issue stage in front of the 4-bit combinational barrel shifter. Commands are
// buffered in a small FIFO and sent to the shifter one at a time. Each result
// is captured together with the mode that produced it and is held until the
// consumer takes it.
module barrel_shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_data,
  input  logic [1:0]       cmd_amt,
  input  logic [2:0]       cmd_mode,
  output logic [3:0]       sh_data_in,
  output logic [1:0]       sh_shift_amt,
  output logic [2:0]       sh_mode,
  input  logic [3:0]       sh_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [2:0]       res_mode,
  output logic [LVL_W-1:0] level
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic [8:0]        head;

  // A full queue refuses new commands even when the head leaves this cycle,
  // so cmd_ready depends only on the registered occupancy.
  assign cmd_ready = (level != LVL_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (level != '0) && ((state == IDLE) || ((state == HOLD) && res_ready));
  assign head      = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_mode, cmd_amt, cmd_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Issue/capture sequencer: load shifter inputs, sample its output one
  // cycle later, then hold the result until the consumer accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sh_data_in   <= '0;
      sh_shift_amt <= '0;
      sh_mode      <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_mode     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sh_data_in   <= head[3:0];
            sh_shift_amt <= head[5:4];
            sh_mode      <= head[8:6];
            state        <= DRIVE;
          end
        end
        DRIVE: begin
          res_data  <= sh_data_out;
          res_mode  <= sh_mode;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              sh_data_in   <= head[3:0];
              sh_shift_amt <= head[5:4];
              sh_mode      <= head[8:6];
              state        <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
